alu_issue_stage: RTL and testbench

- Registered issue stage directly upstream of the 32-bit ALU slice array.
- Accepts an operand pair plus a 4-bit ALU control code and a 3-bit compare selector through a valid/ready handshake.
- Decodes the control code into per-slice controls: A_invert, B_invert, 2-bit operation, carry-in, bonus_control.
- Presents decoded controls and operands from registers, with a 2-entry skid buffer so back-pressure never drops an operation.

---
 rtl/alu_issue_stage.sv | 171 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: registered decode/issue stage with a 2-entry skid buffer in front of the ALU slice array.
// Optional macro ALU_ISSUE_ERR_CHECK_EN: drop illegal control codes and raise a sticky err_o.
`default_nettype none

module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [2:0]       bonus_ctrl_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] src1_o,
  output logic [WIDTH-1:0] src2_o,
  output logic             a_invert_o,
  output logic             b_invert_o,
  output logic [1:0]       operation_o,
  output logic             cin_o,
  output logic [2:0]       bonus_control_o,
  output logic             err_o
);

  localparam int ENTRY_W = 2*WIDTH + 8;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_NAND = 4'b1101;

  logic             dec_a_inv;
  logic             dec_b_inv;
  logic [1:0]       dec_op;
  logic             dec_cin;
  logic [2:0]       dec_bonus;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;
  logic [ENTRY_W-1:0] skid_entry;
  logic [ENTRY_W-1:0] out_entry_n;
  logic [ENTRY_W-1:0] skid_entry_n;
  logic               out_vld;
  logic               skid_vld;
  logic               out_vld_n;
  logic               skid_vld_n;
  logic               ready_q;

  logic               accept;
  logic               consume;
  logic               store;
  logic               store_ok;

  // Unknown codes fall through to the AND encoding with zeroed fields.
  always_comb begin
    dec_a_inv = 1'b0;
    dec_b_inv = 1'b0;
    dec_op    = 2'b00;
    dec_cin   = 1'b0;
    dec_bonus = 3'b000;
    case (alu_ctrl_i)
      CTRL_AND:  dec_op = 2'b00;
      CTRL_OR:   dec_op = 2'b01;
      CTRL_ADD:  dec_op = 2'b10;
      CTRL_SUB: begin
        dec_b_inv = 1'b1;
        dec_op    = 2'b10;
        dec_cin   = 1'b1;
      end
      CTRL_SLT: begin
        dec_b_inv = 1'b1;
        dec_op    = 2'b11;
        dec_cin   = 1'b1;
        dec_bonus = bonus_ctrl_i;
      end
      CTRL_NOR: begin
        dec_a_inv = 1'b1;
        dec_b_inv = 1'b1;
        dec_op    = 2'b00;
      end
      CTRL_NAND: begin
        dec_a_inv = 1'b1;
        dec_b_inv = 1'b1;
        dec_op    = 2'b01;
      end
      default: dec_op = 2'b00;
    endcase
  end

  assign in_entry = {src1_i, src2_i, dec_a_inv, dec_b_inv, dec_op, dec_cin, dec_bonus};

  assign in_ready = ready_q;
  assign accept   = in_valid & ready_q;
  assign consume  = out_vld & out_ready;
  assign store    = accept & store_ok;

`ifdef ALU_ISSUE_ERR_CHECK_EN
  logic dec_legal;
  logic err_q;

  assign dec_legal = (alu_ctrl_i == CTRL_AND) || (alu_ctrl_i == CTRL_OR)  ||
                     (alu_ctrl_i == CTRL_ADD) || (alu_ctrl_i == CTRL_SUB) ||
                     (alu_ctrl_i == CTRL_SLT) || (alu_ctrl_i == CTRL_NOR) ||
                     (alu_ctrl_i == CTRL_NAND);
  assign store_ok  = dec_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && !dec_legal) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign store_ok = 1'b1;
  assign err_o    = 1'b0;
`endif

  // OUT is always the older entry; SKID only refills OUT, never bypasses it.
  always_comb begin
    out_vld_n    = out_vld;
    skid_vld_n   = skid_vld;
    out_entry_n  = out_entry;
    skid_entry_n = skid_entry;
    if (consume && skid_vld) begin
      out_entry_n = skid_entry;
      skid_vld_n  = store;
      if (store) begin
        skid_entry_n = in_entry;
      end
    end else if (store && (!out_vld || consume)) begin
      out_entry_n = in_entry;
      out_vld_n   = 1'b1;
    end else if (store) begin
      skid_entry_n = in_entry;
      skid_vld_n   = 1'b1;
    end else if (consume) begin
      out_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld    <= 1'b0;
      skid_vld   <= 1'b0;
      out_entry  <= '0;
      skid_entry <= '0;
      ready_q    <= 1'b0;
    end else begin
      out_vld    <= out_vld_n;
      skid_vld   <= skid_vld_n;
      out_entry  <= out_entry_n;
      skid_entry <= skid_entry_n;
      ready_q    <= ~skid_vld_n;
    end
  end

  assign out_valid = out_vld;
  assign {src1_o, src2_o, a_invert_o, b_invert_o, operation_o, cin_o, bonus_control_o} = out_entry;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage.
`default_nettype none

module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [3:0]  alu_ctrl_i;
  logic [2:0]  bonus_ctrl_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src1_o;
  logic [31:0] src2_o;
  logic        a_invert_o;
  logic        b_invert_o;
  logic [1:0]  operation_o;
  logic        cin_o;
  logic [2:0]  bonus_control_o;
  logic        err_o;

  int tests;
  int fails;

  logic [72:0] obs;
  assign obs = {out_valid, src1_o, src2_o, a_invert_o, b_invert_o, operation_o, cin_o, bonus_control_o};

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .src1_i(src1_i), .src2_i(src2_i),
    .alu_ctrl_i(alu_ctrl_i), .bonus_ctrl_i(bonus_ctrl_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .src1_o(src1_o), .src2_o(src2_o),
    .a_invert_o(a_invert_o), .b_invert_o(b_invert_o),
    .operation_o(operation_o), .cin_o(cin_o),
    .bonus_control_o(bonus_control_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [2:0] b,
                       input logic [31:0] a1, input logic [31:0] a2);
    in_valid     = v;
    alu_ctrl_i   = c;
    bonus_ctrl_i = b;
    src1_i       = a1;
    src2_i       = a2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'b0010, 3'b000, 32'd1, 32'd2);
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({out_valid, in_ready, err_o} !== 3'b000) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: got valid/ready/err=%b required 000", i, {out_valid, in_ready, err_o});
      end
    end
    rst = 1'b0;
    step();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL reset_release: got valid/ready=%b required 01", {out_valid, in_ready});
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_nothing_emitted: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    drive(1'b1, 4'b0110, 3'b101, 32'd7, 32'd3);
    step();
    in_valid = 1'b0;
    tests++;
    if (obs !== {1'b1, 32'd7, 32'd3, 1'b0, 1'b1, 2'b10, 1'b1, 3'b000}) begin
      fails++;
      $display("FAIL sub_decode: got %h required %h", obs, {1'b1, 32'd7, 32'd3, 1'b0, 1'b1, 2'b10, 1'b1, 3'b000});
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL sub_consumed: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_compare();
    out_ready = 1'b1;
    drive(1'b1, 4'b0111, 3'b100, 32'd5, 32'd9);
    step();
    tests++;
    if (obs !== {1'b1, 32'd5, 32'd9, 1'b0, 1'b1, 2'b11, 1'b1, 3'b100}) begin
      fails++;
      $display("FAIL slt_decode: got %h required %h", obs, {1'b1, 32'd5, 32'd9, 1'b0, 1'b1, 2'b11, 1'b1, 3'b100});
    end
    drive(1'b1, 4'b0010, 3'b100, 32'd1, 32'd2);
    step();
    in_valid = 1'b0;
    tests++;
    if (obs !== {1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000}) begin
      fails++;
      $display("FAIL add_bonus_zero: got %h required %h", obs, {1'b1, 32'd1, 32'd2, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000});
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL compare_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_back_pressure();
    logic [72:0] e_nor, e_nand, e_or;
    e_nor  = {1'b1, 32'h11, 32'h22, 1'b1, 1'b1, 2'b00, 1'b0, 3'b000};
    e_nand = {1'b1, 32'h33, 32'h44, 1'b1, 1'b1, 2'b01, 1'b0, 3'b000};
    e_or   = {1'b1, 32'h55, 32'h66, 1'b0, 1'b0, 2'b01, 1'b0, 3'b000};
    out_ready = 1'b0;
    drive(1'b1, 4'b1100, 3'b111, 32'h11, 32'h22);
    step();
    tests++;
    if ({in_ready, obs} !== {1'b1, e_nor}) begin
      fails++;
      $display("FAIL bp_nor_out: got rdy=%b %h required rdy=1 %h", in_ready, obs, e_nor);
    end
    drive(1'b1, 4'b1101, 3'b111, 32'h33, 32'h44);
    step();
    tests++;
    if ({in_ready, obs} !== {1'b0, e_nor}) begin
      fails++;
      $display("FAIL bp_skid_full: got rdy=%b %h required rdy=0 %h", in_ready, obs, e_nor);
    end
    drive(1'b1, 4'b0001, 3'b111, 32'h55, 32'h66);
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({in_ready, obs} !== {1'b0, e_nor}) begin
        fails++;
        $display("FAIL bp_stall cyc%0d: got rdy=%b %h required rdy=0 %h", i, in_ready, obs, e_nor);
      end
    end
    out_ready = 1'b1;
    step();
    tests++;
    if ({in_ready, obs} !== {1'b1, e_nand}) begin
      fails++;
      $display("FAIL bp_nand_out: got rdy=%b %h required rdy=1 %h", in_ready, obs, e_nand);
    end
    step();
    in_valid = 1'b0;
    tests++;
    if (obs !== e_or) begin
      fails++;
      $display("FAIL bp_or_out: got %h required %h", obs, e_or);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] a1, a2;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a1 = 32'(i * 3 + 1);
      a2 = 32'(i + 100);
      drive(1'b1, 4'b0010, 3'b011, a1, a2);
      step();
      tests++;
      if ({in_ready, obs} !== {1'b1, 1'b1, a1, a2, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000}) begin
        fails++;
        $display("FAIL stream_%0d: got rdy=%b %h required rdy=1 %h", i, in_ready, obs,
                 {1'b1, a1, a2, 1'b0, 1'b0, 2'b10, 1'b0, 3'b000});
      end
    end
    in_valid = 1'b0;
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_drain: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(1'b1, 4'b1010, 3'b111, 32'hA, 32'hB);
    step();
    in_valid = 1'b0;
`ifdef ALU_ISSUE_ERR_CHECK_EN
    tests++;
    if ({out_valid, err_o, in_ready} !== 3'b011) begin
      fails++;
      $display("FAIL illegal_drop: got valid/err/rdy=%b required 011", {out_valid, err_o, in_ready});
    end
    drive(1'b1, 4'b0000, 3'b000, 32'hC, 32'hD);
    step();
    in_valid = 1'b0;
    tests++;
    if ({err_o, obs} !== {1'b1, 1'b1, 32'hC, 32'hD, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000}) begin
      fails++;
      $display("FAIL illegal_sticky: got err=%b %h required err=1 %h", err_o, obs,
               {1'b1, 32'hC, 32'hD, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000});
    end
    step();
    tests++;
    if ({out_valid, err_o} !== 2'b01) begin
      fails++;
      $display("FAIL illegal_sticky2: got valid/err=%b required 01", {out_valid, err_o});
    end
`else
    tests++;
    if ({err_o, obs} !== {1'b0, 1'b1, 32'hA, 32'hB, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000}) begin
      fails++;
      $display("FAIL illegal_as_and: got err=%b %h required err=0 %h", err_o, obs,
               {1'b1, 32'hA, 32'hB, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000});
    end
    step();
    tests++;
    if ({out_valid, err_o} !== 2'b00) begin
      fails++;
      $display("FAIL illegal_after: got valid/err=%b required 00", {out_valid, err_o});
    end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 3'b000, 32'h1, 32'h2);
    step();
    drive(1'b1, 4'b0000, 3'b000, 32'h3, 32'h4);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    tests++;
    if ({out_valid, in_ready, err_o} !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_hold: got valid/ready/err=%b required 000", {out_valid, in_ready, err_o});
    end
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL reset_mid_discard: got valid/ready=%b required 01", {out_valid, in_ready});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0);
    test_reset();
    test_sub();
    test_compare();
    test_back_pressure();
    test_streaming();
    test_illegal();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
